// File: rtl/shifter_pkg.sv
// Shared types and constants for the sequential shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_PASS = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int STRIDE = 4;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single shift step (by 1 or by STRIDE) with carry-out of the last bit leaving.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value_i,
  input  mode_e            mode_i,
  input  logic             stride4_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_o
);

  logic signed [WIDTH-1:0] sval;
  assign sval = value_i;

  always_comb begin
    value_o = value_i;
    carry_o = 1'b0;
    case (mode_i)
      SH_LSL: begin
        if (stride4_i) begin
          value_o = value_i << STRIDE;
          carry_o = value_i[WIDTH-STRIDE];
        end else begin
          value_o = value_i << 1;
          carry_o = value_i[WIDTH-1];
        end
      end
      SH_LSR: begin
        if (stride4_i) begin
          value_o = value_i >> STRIDE;
          carry_o = value_i[STRIDE-1];
        end else begin
          value_o = value_i >> 1;
          carry_o = value_i[0];
        end
      end
      SH_ASR: begin
        if (stride4_i) begin
          value_o = sval >>> STRIDE;
          carry_o = value_i[STRIDE-1];
        end else begin
          value_o = sval >>> 1;
          carry_o = value_i[0];
        end
      end
      default: begin
        value_o = value_i;
        carry_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter with start/done handshake. Optional SHIFTER_STRIDE4_EN
// shifts four positions per cycle while at least four remain.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout,
  output logic             carry
);

  state_e           state_q;
  mode_e            mode_q;
  logic [WIDTH-1:0] val_q;
  logic [AMT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;

  logic             step4;
  logic [AMT_W-1:0] step_amt;
  logic [WIDTH-1:0] val_d;
  logic             carry_d;
  mode_e            mode_in;

`ifdef SHIFTER_STRIDE4_EN
  assign step4 = (32'(cnt_q) >= STRIDE);
`else
  assign step4 = 1'b0;
`endif
  assign step_amt = step4 ? AMT_W'(STRIDE) : AMT_W'(1);
  assign mode_in  = mode_e'(shift);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value_i   (val_q),
    .mode_i    (mode_q),
    .stride4_i (step4),
    .value_o   (val_d),
    .carry_o   (carry_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_SHIFT: begin
          val_q   <= val_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q - step_amt;
          if (cnt_q == step_amt) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a launch, giving back-to-back issue.
          if (start) begin
            val_q   <= in;
            cnt_q   <= amount;
            mode_q  <= mode_in;
            carry_q <= 1'b0;
            if (amount == '0 || mode_in == SH_PASS) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sout  = val_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter; latency expectations follow SHIFTER_STRIDE4_EN.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_r = '0;
  logic [1:0]  shift_r = '0;
  logic [3:0]  amount_r = '0;
  logic        busy, done, carry;
  logic [15:0] sout;

  int checks = 0;
  int errors = 0;

  seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in     (in_r),
    .shift  (shift_r),
    .amount (amount_r),
    .busy   (busy),
    .done   (done),
    .sout   (sout),
    .carry  (carry)
  );

  always #5 clk = ~clk;

  function automatic int exp_lat(input logic [1:0] m, input int a);
    if (m == 2'b00 || a == 0) return 1;
`ifdef SHIFTER_STRIDE4_EN
    return a / 4 + a % 4 + 1;
`else
    return a + 1;
`endif
  endfunction

  // Called one delta after a rising edge; returns in the done cycle (or after timeout).
  task automatic do_op(input logic [15:0] v, input logic [1:0] m, input logic [3:0] a,
                       output int lat, output int bcnt);
    in_r = v; shift_r = m; amount_r = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin lat = c; break; end
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sout !== 16'h0) begin errors++; $display("FAIL reset_sout got %h want 0000", sout); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry); end
    reset = 1'b0;
    idle_cycle();
  endtask

  task automatic test_lsl();
    int lat, bc;
    do_op(16'h8001, 2'b01, 4'd1, lat, bc);
    checks++; if (lat !== exp_lat(2'b01, 1)) begin errors++; $display("FAIL lsl_latency got %0d want %0d", lat, exp_lat(2'b01, 1)); end
    checks++; if (sout !== 16'h0002) begin errors++; $display("FAIL lsl_sout got %h want 0002", sout); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL lsl_carry got %b want 1", carry); end
    checks++; if (bc !== 1) begin errors++; $display("FAIL lsl_busy_cycles got %0d want 1", bc); end
    idle_cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lsl_done_pulse got %b want 0", done); end
    checks++; if (sout !== 16'h0002) begin errors++; $display("FAIL lsl_sout_hold got %h want 0002", sout); end
    do_op(16'hFFFF, 2'b01, 4'd15, lat, bc);
    checks++; if (lat !== exp_lat(2'b01, 15)) begin errors++; $display("FAIL lsl15_latency got %0d want %0d", lat, exp_lat(2'b01, 15)); end
    checks++; if (sout !== 16'h8000) begin errors++; $display("FAIL lsl15_sout got %h want 8000", sout); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL lsl15_carry got %b want 1", carry); end
    idle_cycle();
  endtask

  task automatic test_asr();
    int lat, bc;
    do_op(16'h8000, 2'b11, 4'd15, lat, bc);
    checks++; if (lat !== exp_lat(2'b11, 15)) begin errors++; $display("FAIL asr_latency got %0d want %0d", lat, exp_lat(2'b11, 15)); end
    checks++; if (sout !== 16'hFFFF) begin errors++; $display("FAIL asr_sout got %h want ffff", sout); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL asr_carry got %b want 0", carry); end
    checks++; if (bc !== exp_lat(2'b11, 15) - 1) begin errors++; $display("FAIL asr_busy_cycles got %0d want %0d", bc, exp_lat(2'b11, 15) - 1); end
    idle_cycle();
    do_op(16'h7FFF, 2'b11, 4'd2, lat, bc);
    checks++; if (sout !== 16'h1FFF) begin errors++; $display("FAIL asr_pos_sout got %h want 1fff", sout); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL asr_pos_carry got %b want 1", carry); end
    idle_cycle();
  endtask

  task automatic test_lsr_zero();
    int lat, bc;
    do_op(16'h00F0, 2'b10, 4'd4, lat, bc);
    checks++; if (lat !== exp_lat(2'b10, 4)) begin errors++; $display("FAIL lsr_latency got %0d want %0d", lat, exp_lat(2'b10, 4)); end
    checks++; if (sout !== 16'h000F) begin errors++; $display("FAIL lsr_sout got %h want 000f", sout); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL lsr_carry got %b want 0", carry); end
    idle_cycle();
    do_op(16'h1234, 2'b10, 4'd0, lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
    checks++; if (sout !== 16'h1234) begin errors++; $display("FAIL zero_sout got %h want 1234", sout); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL zero_carry got %b want 0", carry); end
    idle_cycle();
  endtask

  task automatic test_pass();
    int lat, bc;
    do_op(16'hA5A5, 2'b00, 4'd7, lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL pass_latency got %0d want 1", lat); end
    checks++; if (sout !== 16'hA5A5) begin errors++; $display("FAIL pass_sout got %h want a5a5", sout); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL pass_carry got %b want 0", carry); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL pass_busy_cycles got %0d want 0", bc); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    do_op(16'h8001, 2'b01, 4'd1, lat, bc);
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_first_latency got %0d want 2", lat); end
    checks++; if (sout !== 16'h0002) begin errors++; $display("FAIL b2b_first_sout got %h want 0002", sout); end
    // Still in the DONE cycle: launch the next op immediately.
    do_op(16'h00F0, 2'b10, 4'd4, lat, bc);
    checks++; if (lat !== exp_lat(2'b10, 4)) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", lat, exp_lat(2'b10, 4)); end
    checks++; if (sout !== 16'h000F) begin errors++; $display("FAIL b2b_second_sout got %h want 000f", sout); end
    idle_cycle();
  endtask

  task automatic test_ignored_start();
    int ndone;
    logic [15:0] last_sout;
    logic        last_carry;
    in_r = 16'h8000; shift_r = 2'b11; amount_r = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; last_sout = '0; last_carry = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin
        in_r = 16'h0001; shift_r = 2'b01; amount_r = 4'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin ndone++; last_sout = sout; last_carry = carry; end
      @(posedge clk); #1;
    end
    start = 1'b0;
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_dones got %0d want 1", ndone); end
    checks++; if (last_sout !== 16'hFE00) begin errors++; $display("FAIL busy_start_sout got %h want fe00", last_sout); end
    checks++; if (last_carry !== 1'b0) begin errors++; $display("FAIL busy_start_carry got %b want 0", last_carry); end
  endtask

  task automatic test_reset_mid_shift();
    int ndone, lat, bc;
    in_r = 16'h8000; shift_r = 2'b11; amount_r = 4'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 5; c++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
    checks++; if (sout !== 16'h0) begin errors++; $display("FAIL midrst_sout got %h want 0000", sout); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL midrst_carry got %b want 0", carry); end
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
    do_op(16'h00F0, 2'b10, 4'd4, lat, bc);
    checks++; if (lat !== exp_lat(2'b10, 4)) begin errors++; $display("FAIL midrst_after_latency got %0d want %0d", lat, exp_lat(2'b10, 4)); end
    checks++; if (sout !== 16'h000F) begin errors++; $display("FAIL midrst_after_sout got %h want 000f", sout); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_lsl();
    test_asr();
    test_lsr_zero();
    test_pass();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
